// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, one-hot digit
// enables with a dark gap before each digit, frame_done at the end of every full scan.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_blank,
  output logic [3:0]            number,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  // state | meaning
  // IDLE  | scan stopped, all digits dark, number holds
  // BLANK | all digits dark, number already shows the upcoming digit
  // SHOW  | digit idx lit (unless invalid BCD or a suppressed leading zero)
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam int CNT_MAX = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(DIGITS);

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [4*DIGITS-1:0]   active, active_nxt, shadow;
  logic                  pending;
  logic                  frame_end;
  logic [DIGITS-1:0]     lit;
  logic [DIGITS-1:0]     dig_en_nxt;
  logic [3:0]            number_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) begin
          state_nxt = BLANK;
          idx_nxt   = '0;
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == CW'(REFRESH_DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IW'(DIGITS - 1)) begin
            idx_nxt   = '0;
            frame_end = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
    // Dropping en aborts the frame: no frame_done and no buffer swap.
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      frame_end = 1'b0;
    end
  end

  always_comb begin
    active_nxt = active;
    if (frame_end) begin
      if (load)
        active_nxt = value;
      else if (pending)
        active_nxt = shadow;
    end
  end

  always_comb begin
    lit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      lit[k] = (active_nxt[4*k +: 4] <= 4'd9) &&
               !(lz_blank && (k > 0) && ((active_nxt >> (4*k)) == '0));
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    dig_en_nxt = '0;
    number_nxt = number;
    if (state_nxt != IDLE)
      number_nxt = active_nxt[{idx_nxt, 2'b00} +: 4];
    if (state_nxt == SHOW && lit[idx_nxt])
      dig_en_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      number     <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      active     <= active_nxt;
      number     <= number_nxt;
      dig_en     <= dig_en_nxt;
      frame_done <= frame_end;
      if (frame_end) begin
        pending <= 1'b0;
        if (load)
          shadow <= value;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

endmodule
